sample_queue: RTL and testbench



---
 rtl/sample_queue.sv | 75 +++++++
 tb/tb_sample_queue.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sample_queue.sv
// sample_queue: circular stereo sample window; each new sample sweeps all DEPTH pairs,
// oldest first, to a FIR band with registered outputs and a sequencing strobe.
module sample_queue #(
   parameter int DEPTH = 1021,
   parameter int AW    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt_smpl,
   input  logic [15:0] lft_smpl,
   input  logic [15:0] rght_smpl,
   output logic [15:0] lft_out,
   output logic [15:0] rght_out,
   output logic        sequencing
);
   typedef enum logic [1:0] {FILL, IDLE, SEQ} state_t;
   state_t state;
   logic [AW-1:0] new_ptr, old_ptr, rd_ptr, cnt, seq_cnt;
   logic [15:0] lft_mem [DEPTH];
   logic [15:0] rght_mem [DEPTH];
   logic wr_en, rd_en;
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign wr_en = wrt_smpl && (state != SEQ);
   // the terminal sweep cycle issues no read so outputs hold the newest sample
   assign rd_en = (state == SEQ) && (seq_cnt != AW'(DEPTH));
   always_ff @(posedge clk) begin
      if (wr_en) begin
         lft_mem[new_ptr]  <= lft_smpl;
         rght_mem[new_ptr] <= rght_smpl;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         new_ptr    <= '0;
         old_ptr    <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         seq_cnt    <= '0;
         sequencing <= 1'b0;
         lft_out    <= '0;
         rght_out   <= '0;
      end else begin
         if (rd_en) begin
            lft_out  <= lft_mem[rd_ptr];
            rght_out <= rght_mem[rd_ptr];
            rd_ptr   <= nxt(rd_ptr);
         end
         case (state)
            FILL: if (wrt_smpl) begin
               new_ptr <= nxt(new_ptr);
               cnt     <= cnt + 1'b1;
               if (cnt == AW'(DEPTH - 1)) state <= IDLE;
            end
            IDLE: if (wrt_smpl) begin
               new_ptr    <= nxt(new_ptr);
               old_ptr    <= nxt(old_ptr);
               rd_ptr     <= nxt(old_ptr);
               seq_cnt    <= '0;
               sequencing <= 1'b1;
               state      <= SEQ;
            end
            SEQ: if (seq_cnt == AW'(DEPTH)) begin
               sequencing <= 1'b0;
               state      <= IDLE;
            end else begin
               seq_cnt <= seq_cnt + 1'b1;
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_sample_queue.sv
// tb_sample_queue: directed tests for sample_queue at DEPTH=8.
module tb_sample_queue;
   localparam int DEPTH = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wrt_smpl = 1'b0;
   logic [15:0] lft_smpl = '0, rght_smpl = '0;
   logic [15:0] lft_out, rght_out;
   logic sequencing;
   int n = 0, nf = 0;
   logic [15:0] hist[$];

   sample_queue #(.DEPTH(DEPTH), .AW(4)) dut (
      .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .lft_smpl(lft_smpl),
      .rght_smpl(rght_smpl), .lft_out(lft_out), .rght_out(rght_out), .sequencing(sequencing)
   );

   always #5 clk = ~clk;

   // called at a negedge; the strobe is sampled by the following posedge (cycle W)
   task automatic strobe(input logic [15:0] v);
      wrt_smpl = 1'b1;
      lft_smpl = v;
      rght_smpl = -v;
      @(negedge clk);
      wrt_smpl = 1'b0;
   endtask

   task automatic sweep(input logic [15:0] v, input int inj);
      logic [15:0] e, er;
      strobe(v);
      hist.push_back(v);
      n++;
      if (sequencing !== 1'b1) begin nf++; $display("FAIL seq_rise v=%0d got %b want 1", v, sequencing); end
      for (int k = 0; k < DEPTH; k++) begin
         if (k == inj) begin
            wrt_smpl = 1'b1;
            lft_smpl = 16'h7FFF;
            rght_smpl = 16'h8001;
         end
         @(negedge clk);
         wrt_smpl = 1'b0;
         e = hist[hist.size() - DEPTH + k];
         er = -e;
         n++;
         if (sequencing !== 1'b1) begin nf++; $display("FAIL seq_high v=%0d k=%0d got %b want 1", v, k, sequencing); end
         n++;
         if (lft_out !== e) begin nf++; $display("FAIL lft_sweep v=%0d k=%0d got %h want %h", v, k, lft_out, e); end
         n++;
         if (rght_out !== er) begin nf++; $display("FAIL rght_sweep v=%0d k=%0d got %h want %h", v, k, rght_out, er); end
      end
      @(negedge clk);
      n++;
      if (sequencing !== 1'b0) begin nf++; $display("FAIL seq_fall v=%0d got %b want 0", v, sequencing); end
   endtask

   task automatic quiet_fill(input logic [15:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         strobe(base + 16'(i));
         hist.push_back(base + 16'(i));
         for (int c = 0; c < 20; c++) begin
            n++;
            if (sequencing !== 1'b0 || lft_out !== 16'd0 || rght_out !== 16'd0) begin
               nf++;
               $display("FAIL fill i=%0d c=%0d got seq=%b l=%h r=%h want 0/0/0", i, c, sequencing, lft_out, rght_out);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n++;
      if (sequencing !== 1'b0 || lft_out !== 16'd0 || rght_out !== 16'd0) begin
         nf++;
         $display("FAIL reset got seq=%b l=%h r=%h want 0/0/0", sequencing, lft_out, rght_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill;
      quiet_fill(16'd1);
   endtask

   task automatic test_first_sweep;
      sweep(16'd9, -1);
   endtask

   task automatic test_wrap;
      for (int v = 10; v <= 20; v++) begin
         sweep(16'(v), -1);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n++;
            if (sequencing !== 1'b0 || lft_out !== 16'(v)) begin
               nf++;
               $display("FAIL hold v=%0d got seq=%b l=%h want 0/%h", v, sequencing, lft_out, 16'(v));
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      sweep(16'd21, -1);
      sweep(16'd22, -1);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_strobe_during_seq;
      sweep(16'd23, 3);
      repeat (2) @(negedge clk);
      sweep(16'd24, -1);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_async_reset;
      strobe(16'd25);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n++;
      if (sequencing !== 1'b0 || lft_out !== 16'd0 || rght_out !== 16'd0) begin
         nf++;
         $display("FAIL async_reset got seq=%b l=%h r=%h want 0/0/0", sequencing, lft_out, rght_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      hist.delete();
      quiet_fill(16'd100);
      sweep(16'd108, -1);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_first_sweep();
      test_wrap();
      test_back_to_back();
      test_strobe_during_seq();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n, nf);
      $finish;
   end
endmodule
